eth_spi_frame_ctrl: RTL and testbench
=====================================

Name: eth_spi_frame_ctrl

Overview:
- Frame sequencer for the Ethernet PHY/MAC SPI link (W5500-style variable-length data mode).
- Sits directly upstream of the SPI byte engine. It owns chip-select and issues one byte request per transfer.
- Builds each frame as: address high, address low, control byte, then N data bytes.
- Accepts one command at a time from the Ethernet register/socket logic. Streams write data in and read data out.

Parameters:
- LEN_W, 11, width of the data-byte count (max 2047 bytes per frame).
- CS_SETUP, 4, clk cycles between CS falling and the first byte request.
- CS_HOLD, 4, clk cycles between the last byte ack and CS rising.
- TO_CYC, 65535, byte-ack timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- i_cmd_req  in  1  command request; sampled only in IDLE
- i_cmd_rw  in  1  1 = write, 0 = read
- i_cmd_addr  in  16  register offset address
- i_cmd_bsb  in  5  block select bits
- i_cmd_len  in  LEN_W  number of data bytes
- o_busy  out  1  high from accept until DONE exits
- i_wdata  in  8  next write byte; valid whenever o_wdata_rd may fire
- o_wdata_rd  out  1  1-cycle pop strobe; i_wdata consumed this cycle
- o_rdata  out  8  read byte
- o_rdata_vld  out  1  1-cycle strobe qualifying o_rdata
- o_done  out  1  1-cycle frame-complete pulse
- o_err  out  1  1-cycle timeout pulse (tied 0 without the optional feature)
- o_cs_ctrl  out  1  to byte engine CS; active-low, idle 1
- o_byte_req  out  1  1-cycle byte request to the byte engine
- o_byte_tx  out  8  byte to send; held stable from req until ack
- i_byte_ack  in  1  1-cycle byte-complete from the byte engine
- i_byte_rx  in  8  received byte; valid in the ack cycle

Behaviour:
- Reset values: o_cs_ctrl = 1; all other outputs 0; state IDLE; counters 0.
- States: IDLE, SETUP, ADDR_H, ADDR_L, CTRL, DATA, HOLD, DONE.
- IDLE:
  - When i_cmd_req = 1 and i_cmd_len != 0: latch all cmd fields, set o_busy, drop o_cs_ctrl next cycle, go to SETUP.
  - When i_cmd_len = 0: no SPI activity, CS stays high; go to DONE (o_done one cycle after accept).
- SETUP: count CS_SETUP cycles, then go to ADDR_H.
- Each byte state (ADDR_H, ADDR_L, CTRL, DATA):
  - On entry, pulse o_byte_req for exactly 1 cycle with o_byte_tx valid.
  - Wait for i_byte_ack.
  - The next o_byte_req is issued no earlier than the cycle after the ack.
  - i_byte_ack outside a wait is ignored.
- Byte contents:
  - ADDR_H sends addr[15:8].
  - ADDR_L sends addr[7:0].
  - CTRL sends {bsb[4:0], rw, 2'b00} (OM = variable-length mode).
- DATA, write:
  - o_wdata_rd pulses in the same cycle as each o_byte_req.
  - o_byte_tx = i_wdata, registered and held until ack.
- DATA, read:
  - o_byte_tx = 8'h00.
  - On ack: o_rdata = i_byte_rx, o_rdata_vld = 1 in the following cycle.
- Byte counting: the remaining count decrements on each DATA ack. At 0, go to HOLD.
- HOLD: CS stays low for CS_HOLD cycles, then o_cs_ctrl = 1 and go to DONE.
- DONE: pulse o_done, clear o_busy, return to IDLE. A new command can be accepted on the following cycle.
- i_cmd_req while busy: ignored; the requester must hold it until o_busy falls.
- Reset mid-frame: CS rises immediately (asynchronous). No o_done; no partial strobes after reset.
- Address does not auto-increment here; the device handles it.

Optional Feature:
- Macro: ETH_SPI_TIMEOUT_EN
- With it:
  - A per-byte counter starts at o_byte_req and clears on ack.
  - Reaching TO_CYC aborts the frame: CS rises, o_err pulses 1 cycle, o_done is not pulsed, state returns to IDLE.
- Without it: no counter; o_err is tied 0; waits are unbounded.

Decomposition:
- Package eth_spi_pkg holds:
  - state encoding;
  - OM_VDM = 2'b00;
  - RWB_READ / RWB_WRITE;
  - control-byte field positions.
- No sub-module. Counters are inline. The byte engine is instantiated beside this block at the top level, not inside it.

Test Plan:
- Write, addr 0x001F, bsb 0x01, len 2, wdata A5, 3C -> bytes 00, 1F, 0C, A5, 3C; 2 o_wdata_rd pulses; CS low across all 5 bytes; one o_done.
- Read, addr 0x0039, bsb 0x00, len 1, byte engine returns 0x04 -> bytes 00, 39, 00, 00; o_rdata = 04 with one o_rdata_vld; o_done.
- len 0 -> o_cs_ctrl never falls, no o_byte_req, o_done one cycle after accept.
- i_cmd_req pulsed mid-frame -> ignored; frame completes unchanged.
- rst_n asserted during DATA -> o_cs_ctrl = 1 at once, all strobes 0, IDLE after release.
- With ETH_SPI_TIMEOUT_EN and TO_CYC = 16: withhold ack -> o_err pulse 16 cycles after req, CS high, no o_done.

Source files
------------

// File: rtl/eth_spi_pkg.sv
// eth_spi_pkg: state encoding and control-byte layout for the Ethernet SPI frame sequencer
package eth_spi_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ADDR_H, S_ADDR_L, S_CTRL, S_DATA, S_HOLD, S_DONE
    } state_t;
    localparam logic [1:0] OM_VDM = 2'b00;
    localparam logic RWB_READ = 1'b0;
    localparam logic RWB_WRITE = 1'b1;
    localparam int CTRL_BSB_LSB = 3;
    localparam int CTRL_RWB_BIT = 2;
    localparam int CTRL_OM_LSB = 0;
    function automatic logic [7:0] ctrl_byte(input logic [4:0] bsb, input logic rw);
        logic [7:0] b;
        b = '0;
        b[CTRL_BSB_LSB +: 5] = bsb;
        b[CTRL_RWB_BIT] = rw;
        b[CTRL_OM_LSB +: 2] = OM_VDM;
        return b;
    endfunction
endpackage

// File: rtl/eth_spi_frame_ctrl.sv
// eth_spi_frame_ctrl: sequences addr/ctrl/data bytes of one SPI frame under chip-select
// Optional per-byte ack timeout enabled by ETH_SPI_TIMEOUT_EN.
module eth_spi_frame_ctrl
    import eth_spi_pkg::*;
#(
    parameter int LEN_W = 11,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD = 4,
    parameter int TO_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cmd_req,
    input  logic             i_cmd_rw,
    input  logic [15:0]      i_cmd_addr,
    input  logic [4:0]       i_cmd_bsb,
    input  logic [LEN_W-1:0] i_cmd_len,
    output logic             o_busy,
    input  logic [7:0]       i_wdata,
    output logic             o_wdata_rd,
    output logic [7:0]       o_rdata,
    output logic             o_rdata_vld,
    output logic             o_done,
    output logic             o_err,
    output logic             o_cs_ctrl,
    output logic             o_byte_req,
    output logic [7:0]       o_byte_tx,
    input  logic             i_byte_ack,
    input  logic [7:0]       i_byte_rx
);
    localparam int CNT_W = $clog2((CS_SETUP > CS_HOLD ? CS_SETUP : CS_HOLD) + 1);

    state_t            r_state, w_next;
    logic [15:0]       r_addr;
    logic [4:0]        r_bsb;
    logic              r_rw;
    logic [LEN_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wait, r_rvld;
    logic [7:0]        r_tx, r_rdata;
    logic              w_byte_st, w_ack, w_cnt_end, w_to;
    logic [7:0]        w_tx;

    assign w_byte_st = r_state inside {S_ADDR_H, S_ADDR_L, S_CTRL, S_DATA};
    assign w_ack = w_byte_st && r_wait && i_byte_ack;
    assign w_cnt_end = (r_state == S_SETUP && r_cnt == CNT_W'(CS_SETUP - 1)) ||
                       (r_state == S_HOLD && r_cnt == CNT_W'(CS_HOLD - 1));

`ifdef ETH_SPI_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] r_to;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_to <= '0;
        else r_to <= (w_byte_st && r_wait && !i_byte_ack) ? r_to + 1'b1 : '0;
    assign w_to = w_byte_st && r_wait && !i_byte_ack && r_to == TO_W'(TO_CYC - 1);
`else
    assign w_to = (TO_CYC == 0) & 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_cmd_req) w_next = (i_cmd_len == '0) ? S_DONE : S_SETUP;
            S_SETUP:  if (w_cnt_end) w_next = S_ADDR_H;
            S_ADDR_H: if (w_ack) w_next = S_ADDR_L;
            S_ADDR_L: if (w_ack) w_next = S_CTRL;
            S_CTRL:   if (w_ack) w_next = S_DATA;
            S_DATA:   if (w_ack && r_len == LEN_W'(1)) w_next = S_HOLD;
            S_HOLD:   if (w_cnt_end) w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
        if (w_to) w_next = S_IDLE;
    end

    always_comb begin
        o_busy = r_state != S_IDLE;
        o_cs_ctrl = !(r_state inside {S_SETUP, S_ADDR_H, S_ADDR_L, S_CTRL, S_DATA, S_HOLD});
        o_byte_req = w_byte_st && !r_wait;
        o_wdata_rd = o_byte_req && r_state == S_DATA && r_rw == RWB_WRITE;
        w_tx = r_state == S_ADDR_H ? r_addr[15:8] :
               r_state == S_ADDR_L ? r_addr[7:0] :
               r_state == S_CTRL   ? ctrl_byte(r_bsb, r_rw) :
               r_rw == RWB_WRITE   ? i_wdata : 8'h00;
        // The first cycle presents the live byte; afterwards the captured copy holds it until ack.
        o_byte_tx = r_wait ? r_tx : (o_byte_req ? w_tx : 8'h00);
        o_rdata = r_rdata;
        o_rdata_vld = r_rvld;
        o_done = r_state == S_DONE;
        o_err = w_to;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_addr <= '0;
            r_bsb <= '0;
            r_rw <= RWB_READ;
            r_len <= '0;
            r_cnt <= '0;
            r_wait <= 1'b0;
            r_tx <= '0;
            r_rdata <= '0;
            r_rvld <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_cmd_req) begin
                r_addr <= i_cmd_addr;
                r_bsb <= i_cmd_bsb;
                r_rw <= i_cmd_rw;
                r_len <= i_cmd_len;
            end
            r_cnt <= (w_next == r_state && (r_state == S_SETUP || r_state == S_HOLD)) ? r_cnt + 1'b1 : '0;
            r_wait <= w_to ? 1'b0 : o_byte_req ? 1'b1 : w_ack ? 1'b0 : r_wait;
            if (o_byte_req) r_tx <= w_tx;
            if (w_ack && r_state == S_DATA) r_len <= r_len - 1'b1;
            r_rvld <= w_ack && r_state == S_DATA && r_rw == RWB_READ;
            if (w_ack && r_state == S_DATA && r_rw == RWB_READ) r_rdata <= i_byte_rx;
        end
endmodule

// File: tb/tb_eth_spi_frame_ctrl.sv
// tb_eth_spi_frame_ctrl: directed frames against a small byte-engine model with hand-computed bytes
module tb_eth_spi_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_cmd_req = 1'b0, i_cmd_rw = 1'b0;
    logic [15:0] i_cmd_addr = '0;
    logic [4:0]  i_cmd_bsb = '0;
    logic [10:0] i_cmd_len = '0;
    logic [7:0]  i_wdata = '0, i_byte_rx = '0;
    logic        i_byte_ack = 1'b0;
    logic        o_busy, o_wdata_rd, o_rdata_vld, o_done, o_err, o_cs_ctrl, o_byte_req;
    logic [7:0]  o_rdata, o_byte_tx;

    eth_spi_frame_ctrl #(.LEN_W(11), .CS_SETUP(4), .CS_HOLD(4), .TO_CYC(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_cmd_req(i_cmd_req), .i_cmd_rw(i_cmd_rw),
        .i_cmd_addr(i_cmd_addr), .i_cmd_bsb(i_cmd_bsb), .i_cmd_len(i_cmd_len),
        .o_busy(o_busy), .i_wdata(i_wdata), .o_wdata_rd(o_wdata_rd), .o_rdata(o_rdata),
        .o_rdata_vld(o_rdata_vld), .o_done(o_done), .o_err(o_err), .o_cs_ctrl(o_cs_ctrl),
        .o_byte_req(o_byte_req), .o_byte_tx(o_byte_tx), .i_byte_ack(i_byte_ack),
        .i_byte_rx(i_byte_rx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [7:0] q[$];
    logic [7:0] wbuf[4];
    logic [7:0] rx_val = 8'h00, held = 8'h00, last_rdata = 8'h00;
    int wbase = 0, wrd_cnt = 0, vld_cnt = 0, done_cnt = 0, err_cnt = 0;
    int fall_cnt = 0, req_cs_hi = 0, hold_err = 0, ack_dly = 0;
    int cyc = 0, req_cyc = 0, err_cyc = 0;
    logic withhold = 1'b0, prev_cs = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte-engine model and event recorder; acks 3 cycles after each request.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            ack_dly = 0;
            i_byte_ack = 1'b0;
        end else begin
            i_byte_ack = 1'b0;
            i_wdata = wbuf[(wrd_cnt - wbase) & 3];
            if (o_byte_req) begin
                q.push_back(o_byte_tx);
                held = o_byte_tx;
                ack_dly = 3;
                req_cyc = cyc;
                if (o_cs_ctrl) req_cs_hi++;
            end else if (ack_dly > 0) begin
                if (o_byte_tx != held) hold_err++;
                ack_dly--;
                if (ack_dly == 0 && !withhold) begin
                    i_byte_ack = 1'b1;
                    i_byte_rx = rx_val;
                end
            end
            if (o_wdata_rd) wrd_cnt++;
            if (o_rdata_vld) begin vld_cnt++; last_rdata = o_rdata; end
            if (o_done) done_cnt++;
            if (o_err) begin err_cnt++; err_cyc = cyc; end
            if (prev_cs && !o_cs_ctrl) fall_cnt++;
        end
        prev_cs = o_cs_ctrl;
    end

    task automatic issue(input logic rw, input logic [15:0] addr, input logic [4:0] bsb, input logic [10:0] len);
        @(posedge clk); #1;
        i_cmd_req = 1'b1; i_cmd_rw = rw; i_cmd_addr = addr; i_cmd_bsb = bsb; i_cmd_len = len;
        @(posedge clk); #1;
        i_cmd_req = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 400) begin @(posedge clk); n++; end
        chk("done_seen", 32'(done_cnt != d0), 32'd1);
    endtask

    int b0, w0, d0, v0, f0, n;
    initial begin
        wbuf[0] = 8'h00; wbuf[1] = 8'h00; wbuf[2] = 8'h00; wbuf[3] = 8'h00;
        #12;
        chk("rst_cs", 32'(o_cs_ctrl), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_req", 32'(o_byte_req), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        rst_n = 1'b1;

        // Write 2 bytes: 00 1F 0C A5 3C
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C; wbase = wrd_cnt;
        b0 = q.size(); w0 = wrd_cnt; d0 = done_cnt; f0 = fall_cnt;
        issue(1'b1, 16'h001F, 5'h01, 11'd2);
        chk("wr_busy", 32'(o_busy), 32'd1);
        wait_done(d0);
        chk("wr_nbytes", 32'(q.size() - b0), 32'd5);
        chk("wr_b0", 32'(q[b0]), 32'h00);
        chk("wr_b1", 32'(q[b0+1]), 32'h1F);
        chk("wr_b2", 32'(q[b0+2]), 32'h0C);
        chk("wr_b3", 32'(q[b0+3]), 32'hA5);
        chk("wr_b4", 32'(q[b0+4]), 32'h3C);
        chk("wr_pops", 32'(wrd_cnt - w0), 32'd2);
        chk("wr_cs_falls", 32'(fall_cnt - f0), 32'd1);
        chk("wr_req_cs_hi", 32'(req_cs_hi), 32'd0);
        chk("wr_tx_held", 32'(hold_err), 32'd0);
        @(posedge clk); #1;
        chk("wr_done_once", 32'(done_cnt - d0), 32'd1);
        chk("wr_idle_busy", 32'(o_busy), 32'd0);
        chk("wr_idle_cs", 32'(o_cs_ctrl), 32'd1);

        // Read 1 byte: 00 39 00 00, rdata 04
        rx_val = 8'h04;
        b0 = q.size(); v0 = vld_cnt; d0 = done_cnt;
        issue(1'b0, 16'h0039, 5'h00, 11'd1);
        wait_done(d0);
        chk("rd_nbytes", 32'(q.size() - b0), 32'd4);
        chk("rd_b0", 32'(q[b0]), 32'h00);
        chk("rd_b1", 32'(q[b0+1]), 32'h39);
        chk("rd_b2", 32'(q[b0+2]), 32'h00);
        chk("rd_b3", 32'(q[b0+3]), 32'h00);
        chk("rd_vld", 32'(vld_cnt - v0), 32'd1);
        chk("rd_data", 32'(last_rdata), 32'h04);

        // Zero length: no CS activity, done the cycle after accept
        b0 = q.size(); d0 = done_cnt; f0 = fall_cnt;
        issue(1'b1, 16'h1234, 5'h02, 11'd0);
        chk("len0_done_now", 32'(o_done), 32'd1);
        chk("len0_cs", 32'(o_cs_ctrl), 32'd1);
        repeat (3) @(posedge clk);
        chk("len0_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("len0_no_bytes", 32'(q.size() - b0), 32'd0);
        chk("len0_no_fall", 32'(fall_cnt - f0), 32'd0);

        // Request pulsed mid-frame is ignored
        wbuf[0] = 8'h5A; wbase = wrd_cnt;
        b0 = q.size(); d0 = done_cnt;
        issue(1'b1, 16'h1234, 5'h1F, 11'd1);
        repeat (10) @(posedge clk);
        #1;
        i_cmd_req = 1'b1; i_cmd_rw = 1'b0; i_cmd_addr = 16'hFFFF; i_cmd_bsb = 5'h07; i_cmd_len = 11'd0;
        @(posedge clk); #1;
        i_cmd_req = 1'b0;
        wait_done(d0);
        repeat (3) @(posedge clk);
        chk("mid_nbytes", 32'(q.size() - b0), 32'd4);
        chk("mid_b0", 32'(q[b0]), 32'h12);
        chk("mid_b1", 32'(q[b0+1]), 32'h34);
        chk("mid_b2", 32'(q[b0+2]), 32'hFC);
        chk("mid_b3", 32'(q[b0+3]), 32'h5A);
        chk("mid_done_once", 32'(done_cnt - d0), 32'd1);

        // Reset during DATA
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbase = wrd_cnt;
        b0 = q.size(); d0 = done_cnt;
        issue(1'b1, 16'h0100, 5'h03, 11'd3);
        n = 0;
        while (q.size() - b0 < 4 && n < 200) begin @(posedge clk); n++; end
        chk("rst_reached_data", 32'(q.size() - b0 >= 4), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(o_cs_ctrl), 32'd1);
        chk("mid_rst_req", 32'(o_byte_req), 32'd0);
        chk("mid_rst_wrd", 32'(o_wdata_rd), 32'd0);
        chk("mid_rst_vld", 32'(o_rdata_vld), 32'd0);
        chk("mid_rst_done", 32'(o_done), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(o_busy), 32'd0);
        chk("post_rst_cs", 32'(o_cs_ctrl), 32'd1);
        chk("post_rst_no_done", 32'(done_cnt - d0), 32'd0);

        // Recovery: a read after reset runs normally
        rx_val = 8'hC3;
        b0 = q.size(); d0 = done_cnt;
        issue(1'b0, 16'h0002, 5'h08, 11'd1);
        wait_done(d0);
        chk("rec_b2", 32'(q[b0+2]), 32'h40);
        chk("rec_data", 32'(last_rdata), 32'hC3);
        chk("no_err", 32'(err_cnt), 32'd0);

`ifdef ETH_SPI_TIMEOUT_EN
        withhold = 1'b1;
        d0 = done_cnt;
        issue(1'b0, 16'h0003, 5'h00, 11'd1);
        n = 0;
        while (err_cnt == 0 && n < 200) begin @(posedge clk); n++; end
        chk("to_err_seen", 32'(err_cnt), 32'd1);
        chk("to_err_delay", 32'(err_cyc - req_cyc), 32'd16);
        @(posedge clk); #1;
        chk("to_cs_high", 32'(o_cs_ctrl), 32'd1);
        chk("to_idle", 32'(o_busy), 32'd0);
        repeat (4) @(posedge clk);
        chk("to_no_done", 32'(done_cnt - d0), 32'd0);
        withhold = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
